// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin SPI mode-0 bus arbiter with built-in byte shift engine.
// Optional WAIT-state idle timeout is enabled with the SPI_ARB_TIMEOUT_EN macro.
module spi_bus_arbiter #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_DATA,
  input  logic       REQ0_LAST,
  output logic       REQ0_READY,
  output logic       RSP0_VALID,
  output logic [7:0] RSP0_DATA,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_DATA,
  input  logic       REQ1_LAST,
  output logic       REQ1_READY,
  output logic       RSP1_VALID,
  output logic [7:0] RSP1_DATA,
  input  logic       SPI_MISO,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  output logic       SPI_CS,
  output logic       BUSY,
  output logic       OWNER
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic       TIMEOUT_ERR
`endif
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // One counter serves both the CS gap and the WAIT idle timeout.
  localparam int CNT_MAX = (CS_GAP > TIMEOUT) ? CS_GAP : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_busy;
  logic               r_cs;
  logic               r_sclk;
  logic [7:0]         r_tx;
  logic [7:0]         r_rx;
  logic [DIV_W-1:0]   r_div;
  logic [4:0]         r_edge;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_owner;
  logic               r_ptr;
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [7:0]         r_rsp0_data;
  logic [7:0]         r_rsp1_data;
`ifdef SPI_ARB_TIMEOUT_EN
  logic               r_tmo_err;
  logic               w_timeout;
`endif

  logic [1:0]         w_valid;
  logic [1:0]         w_ready;
  logic               w_accept;
  logic               w_byte_done;
  logic               w_tick;
  logic               w_grant;
  logic [7:0]         w_data;
  logic               w_last;

  assign w_valid = {REQ1_VALID, REQ0_VALID};
  assign w_grant = w_ready[1];
  assign w_data  = w_grant ? REQ1_DATA : REQ0_DATA;
  assign w_last  = w_grant ? REQ1_LAST : REQ0_LAST;

  // State register; BUSY is registered from the next-state decode.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  // Next-state, arbitration and shift-engine strobes.
  always_comb begin
    w_next      = r_state;
    w_ready     = 2'b00;
    w_byte_done = 1'b0;
    w_tick      = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_valid[r_ptr]) begin
          w_ready = r_ptr ? 2'b10 : 2'b01;
        end else if (w_valid[~r_ptr]) begin
          w_ready = r_ptr ? 2'b01 : 2'b10;
        end else begin
          w_ready = 2'b00;
        end
        if (|(w_ready & w_valid)) begin
          w_next = ST_SHIFT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_edge == 5'd16) begin
          w_byte_done = 1'b1;
          w_next      = r_last ? ST_GAP : ST_WAIT;
        end else begin
          w_tick = (r_div == DIV_W'(CLK_DIV - 1));
          w_next = ST_SHIFT;
        end
      end
      ST_WAIT: begin
        w_ready = r_owner ? 2'b10 : 2'b01;
        if (|(w_ready & w_valid)) begin
          w_next = ST_SHIFT;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_GAP;
`endif
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(CS_GAP - 1)) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_GAP;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    w_accept = |(w_ready & w_valid);
  end

  // Datapath: byte latch, SPI clock generation, shift registers, responses.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cs         <= 1'b1;
      r_sclk       <= 1'b0;
      r_tx         <= 8'h00;
      r_rx         <= 8'h00;
      r_div        <= '0;
      r_edge       <= 5'd0;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_owner      <= 1'b0;
      r_ptr        <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= 8'h00;
      r_rsp1_data  <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
      r_tmo_err    <= 1'b0;
`endif
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_tmo_err    <= 1'b0;
`endif
      if (w_accept) begin
        r_tx    <= w_data;
        r_last  <= w_last;
        r_owner <= w_grant;
        r_cs    <= 1'b0;
        r_sclk  <= 1'b0;
        r_div   <= '0;
        r_edge  <= 5'd0;
        r_cnt   <= '0;
      end else if (w_byte_done) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_data  <= r_rx;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_data  <= r_rx;
        end
        r_cnt <= '0;
        if (r_last) begin
          r_cs  <= 1'b1;
          r_ptr <= ~r_owner;
        end
      end else if (w_tick) begin
        // Rising edge samples MISO; falling edge presents the next MOSI bit.
        r_div  <= '0;
        r_edge <= r_edge + 5'd1;
        r_sclk <= ~r_sclk;
        if (!r_sclk) begin
          r_rx <= {r_rx[6:0], SPI_MISO};
        end else begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end else if (r_state == ST_SHIFT) begin
        r_div <= r_div + DIV_W'(1);
`ifdef SPI_ARB_TIMEOUT_EN
      end else if (w_timeout) begin
        r_cs      <= 1'b1;
        r_ptr     <= ~r_owner;
        r_cnt     <= '0;
        r_tmo_err <= 1'b1;
`endif
      end else if (r_state == ST_WAIT || r_state == ST_GAP) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign REQ0_READY = w_ready[0];
  assign REQ1_READY = w_ready[1];
  assign RSP0_VALID = r_rsp0_valid;
  assign RSP1_VALID = r_rsp1_valid;
  assign RSP0_DATA  = r_rsp0_data;
  assign RSP1_DATA  = r_rsp1_data;
  assign SPI_CLK    = r_sclk;
  assign SPI_MOSI   = r_tx[7];
  assign SPI_CS     = r_cs;
  assign BUSY       = r_busy;
  assign OWNER      = r_owner;
`ifdef SPI_ARB_TIMEOUT_EN
  assign TIMEOUT_ERR = r_tmo_err;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter against a timeline-based transaction model.
module tb_spi_bus_arbiter;

  localparam int CD        = 4;
  localparam int GAPC      = 2;
  localparam int SHIFT_LEN = 16 * CD + 2;
  localparam int PH_IDLE   = 0;
  localparam int PH_SHIFT  = 1;
  localparam int PH_WAIT   = 2;
  localparam int PH_GAP    = 3;

  logic       CLK;
  logic       RESETN;
  logic       REQ0_VALID, REQ0_LAST, REQ0_READY, RSP0_VALID;
  logic [7:0] REQ0_DATA, RSP0_DATA;
  logic       REQ1_VALID, REQ1_LAST, REQ1_READY, RSP1_VALID;
  logic [7:0] REQ1_DATA, RSP1_DATA;
  logic       SPI_MISO, SPI_CLK, SPI_MOSI, SPI_CS, BUSY, OWNER;
  logic       tb_inv;
`ifdef SPI_ARB_TIMEOUT_EN
  logic       TIMEOUT_ERR;
`endif

  // Slave echoes MOSI, optionally inverted per byte, so RX is distinguishable from TX.
  assign SPI_MISO = SPI_MOSI ^ tb_inv;

  spi_bus_arbiter #(.CLK_DIV(CD), .CS_GAP(GAPC)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_LAST(REQ0_LAST),
    .REQ0_READY(REQ0_READY), .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_LAST(REQ1_LAST),
    .REQ1_READY(REQ1_READY), .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA),
    .SPI_MISO(SPI_MISO), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
    .BUSY(BUSY), .OWNER(OWNER)
`ifdef SPI_ARB_TIMEOUT_EN
    , .TIMEOUT_ERR(TIMEOUT_ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_err;
  int cyc;

  // Model: time of last accept plus what was accepted; everything else follows by arithmetic.
  int         m_acc;
  bit         m_last;
  bit         m_owner;
  bit         m_ptr;
  logic [7:0] m_byte;
  logic       m_inv;
  logic [7:0] m_rsp [2];
  int         m_phase;
  int         m_k;

  int         d_rem  [2];
  int         d_wait [2];
  logic [7:0] d_data [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_acc    = -1000;
    m_last   = 1'b1;
    m_owner  = 1'b0;
    m_ptr    = 1'b0;
    m_byte   = 8'h00;
    m_inv    = 1'b0;
    m_rsp[0] = 8'h00;
    m_rsp[1] = 8'h00;
    for (int n = 0; n < 2; n++) begin
      d_rem[n]  = 0;
      d_wait[n] = 0;
      d_data[n] = 8'h00;
    end
    tb_inv     = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    REQ0_DATA  = 8'h00;
    REQ1_DATA  = 8'h00;
    REQ0_LAST  = 1'b0;
    REQ1_LAST  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ctl", 32'({SPI_CS, SPI_CLK, BUSY, OWNER, RSP1_VALID, RSP0_VALID}), 32'(6'b100000));
    chk("rst_data", 32'({RSP1_DATA, RSP0_DATA}), 32'(16'h0000));
    chk("rst_mosi", 32'(SPI_MOSI), 32'(1'b0));
    chk("rst_ready", 32'({REQ1_READY, REQ0_READY}), 32'(2'b00));
  endtask

  task automatic step();
    logic [1:0] vld;
    logic [1:0] exp_rdy;
    logic [1:0] rspv;
    logic       exp_sclk;
    logic       exp_mosi;
    bit         win;
    bit         acc;
    int         t_end;
    int         bi;
    @(negedge CLK);
    m_k   = cyc - m_acc - 1;
    t_end = m_acc + SHIFT_LEN;
    if (m_k >= 0 && m_k <= 16 * CD) m_phase = PH_SHIFT;
    else if (!m_last)               m_phase = PH_WAIT;
    else if (cyc < t_end + GAPC)    m_phase = PH_GAP;
    else                            m_phase = PH_IDLE;
    rspv = 2'b00;
    if (cyc == t_end) begin
      rspv[m_owner]  = 1'b1;
      m_rsp[m_owner] = m_byte ^ {8{m_inv}};
    end
    exp_sclk = (m_phase == PH_SHIFT) ? 1'((m_k / CD) % 2) : 1'b0;
    chk("ctl", 32'({SPI_CS, SPI_CLK, BUSY, OWNER, RSP1_VALID, RSP0_VALID}),
        32'({(m_phase == PH_IDLE || m_phase == PH_GAP), exp_sclk, (m_phase != PH_IDLE), m_owner, rspv}));
    chk("rsp_data", 32'({RSP1_DATA, RSP0_DATA}), 32'({m_rsp[1], m_rsp[0]}));
    if (m_phase == PH_SHIFT) begin
      bi       = m_k / (2 * CD);
      exp_mosi = (bi < 8) ? m_byte[7 - bi] : 1'b0;
      chk("mosi", 32'(SPI_MOSI), 32'(exp_mosi));
    end
`ifdef SPI_ARB_TIMEOUT_EN
    chk("tmo_err", 32'(TIMEOUT_ERR), 32'(1'b0));
`endif
    for (int n = 0; n < 2; n++) begin
      if (d_wait[n] > 0) begin
        vld[n] = 1'b0;
        d_wait[n]--;
      end else begin
        if (d_rem[n] == 0) begin
          d_rem[n]  = int'($urandom_range(1, 4));
          d_data[n] = 8'($urandom);
        end
        vld[n] = 1'b1;
      end
    end
    REQ0_VALID = vld[0];
    REQ0_DATA  = vld[0] ? d_data[0] : 8'($urandom);
    REQ0_LAST  = vld[0] ? (d_rem[0] == 1) : 1'($urandom);
    REQ1_VALID = vld[1];
    REQ1_DATA  = vld[1] ? d_data[1] : 8'($urandom);
    REQ1_LAST  = vld[1] ? (d_rem[1] == 1) : 1'($urandom);
    #1;
    exp_rdy = 2'b00;
    win     = 1'b0;
    if (m_phase == PH_IDLE) begin
      win = vld[m_ptr] ? m_ptr : !m_ptr;
      if (vld[win]) exp_rdy[win] = 1'b1;
    end else if (m_phase == PH_WAIT) begin
      win          = m_owner;
      exp_rdy[win] = 1'b1;
    end
    chk("ready", 32'({REQ1_READY, REQ0_READY}), 32'(exp_rdy));
    acc = |(exp_rdy & vld);
    if (acc) begin
      m_acc   = cyc;
      m_owner = win;
      m_byte  = d_data[win];
      m_last  = (d_rem[win] == 1);
      m_inv   = 1'($urandom);
      tb_inv  = m_inv;
      if (m_last) m_ptr = !win;
      d_rem[win]--;
      d_data[win] = 8'($urandom);
      if (d_rem[win] == 0) d_wait[win] = int'($urandom_range(0, 8));
      else if ($urandom_range(0, 3) == 0) d_wait[win] = 10;
      else d_wait[win] = int'($urandom_range(0, 3));
    end
    cyc++;
  endtask

  initial begin
    bit found;
    n_cmp  = 0;
    n_err  = 0;
    cyc    = 0;
    RESETN = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    RESETN = 1'b1;

    for (int i = 0; i < 4000 && n_err < 40; i++) step();

    // Hit reset exactly when the third SPI_CLK rising edge becomes visible.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found && n_err < 40; i++) begin
      step();
      if (m_phase == PH_SHIFT && m_k == 5 * CD) found = 1'b1;
    end
    chk("third_rise_seen", 32'(found), 32'(1'b1));
    RESETN = 1'b0;
    #1;
    chk("midbyte_rst_ctl", 32'({SPI_CS, SPI_CLK, BUSY, RSP1_VALID, RSP0_VALID}), 32'(5'b10000));
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    RESETN = 1'b1;

    for (int i = 0; i < 2000 && n_err < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the SoC's single SPI bus (SPI_CLK/SPI_MOSI/SPI_MISO/SPI_CS) between two byte-stream requesters, e.g. the CPU SPI peripheral and an LCD refresh engine.
- Grants the bus per burst using round-robin. Holds CS low for the whole burst.
- Contains the SPI mode-0 shift engine and returns each received byte to the owning requester.

Parameters:
CLK_DIV, 4, SPI half-period in CLK cycles (>=1)
CS_GAP, 2, CLK cycles CS is held high between bursts (>=1)
TIMEOUT, 255, WAIT-state idle limit in CLK cycles (only used with SPI_ARB_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 has a byte to send
REQ0_DATA  in  8  requester 0 transmit byte
REQ0_LAST  in  1  byte is the final byte of the burst
REQ0_READY  out  1  byte accepted this cycle
RSP0_VALID  out  1  one-cycle pulse, received byte valid
RSP0_DATA  out  8  received byte
REQ1_VALID/REQ1_DATA/REQ1_LAST/REQ1_READY/RSP1_VALID/RSP1_DATA  same as requester 0
SPI_MISO  in  1  serial data in
SPI_CLK  out  1  serial clock, idles low
SPI_MOSI  out  1  serial data out, MSB first
SPI_CS  out  1  chip select, active low
BUSY  out  1  high whenever state != IDLE
OWNER  out  1  index of the current/last granted requester

Behaviour:
- Clock/reset: one clock, CLK. RESETN is asynchronous, active-low; reset is applied immediately regardless of state, including mid-byte.
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, READYx=0, RSPx_VALID=0, RSPx_DATA=0, BUSY=0, OWNER=0, round-robin pointer=0, state=IDLE.
- States: IDLE, SHIFT, WAIT, GAP.
- IDLE:
  - Arbitration: pointer requester wins if its VALID is high; otherwise the other requester wins if its VALID is high.
  - READY is combinational and high only for the winner.
  - Accept = VALID&&READY. On accept, latch DATA and LAST, set OWNER, go to SHIFT.
- SHIFT:
  - On the cycle after accept, SPI_CS=0 and SPI_MOSI=bit7.
  - SPI_CLK toggles every CLK_DIV cycles: 8 rising and 8 falling edges.
  - MISO is sampled on each rising edge. MOSI advances to the next bit on each falling edge.
  - After the 8th falling edge, SPI_CLK=0 and RSPn_VALID pulses for exactly 1 cycle with the received byte.
  - That pulse occurs 16*CLK_DIV+2 cycles after the accepting cycle (66 at default).
  - Then go to GAP if LAST was latched, else to WAIT.
- WAIT:
  - SPI_CS stays low. READY is high only for OWNER; the other requester's READY=0.
  - Accept goes to SHIFT with the same timing as above.
- GAP:
  - SPI_CS=1 for exactly CS_GAP cycles, then IDLE.
  - The pointer is set to !OWNER on entry to GAP.
- READY is never high for both requesters in the same cycle, and is never high in SHIFT or GAP.
- RSPx_DATA holds its value until the next RSPx_VALID.
- Requester VALID changes during SHIFT are ignored.
- The non-owner waits for the owner's entire burst; there is no preemption.
- Both VALIDs high in IDLE: the pointer requester wins; the loser wins the next arbitration if it is still valid.
- Without the timeout feature, an owner that stalls in WAIT holds the bus indefinitely.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on accept.
  - On reaching TIMEOUT cycles with no owner accept, go to GAP: CS released, pointer advanced.
  - Extra output TIMEOUT_ERR (out, 1) pulses for 1 cycle on that transition; its reset value is 0.
- Undefined: no counter, no TIMEOUT_ERR port, and WAIT has no exit other than accept or reset.

Test Plan:
- Single byte: REQ0 sends 0xA5 LAST=1, MISO loopback from MOSI -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; RSP0_VALID at accept+66 with 0xA5; CS high for 2 cycles then BUSY=0.
- Burst: REQ1 sends 0x01,0x02,0x03 (LAST on 0x03) with a 10-cycle stall before 0x02 -> CS stays low through the stall; 3 RSP1_VALID pulses; REQ0 held valid throughout gets no READY until GAP ends.
- Contention: both VALID in IDLE after reset -> REQ0 granted first, then REQ1, then REQ0 (alternation over 4 single-byte bursts).
- Reset mid-byte: assert RESETN=0 at the 3rd SPI_CLK rising edge -> same cycle SPI_CS=1, SPI_CLK=0, BUSY=0, no RSP pulse; a new transfer after release completes normally.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT=20): REQ0 sends 0x11 LAST=0 then drops VALID -> TIMEOUT_ERR pulse 20 cycles into WAIT, CS high, pending REQ1 granted after GAP.
